// File: rtl/rrag_pkg.sv
// Shared types for the REP string sequencer: FSM states, REP condition
// encodings and the element-size to stride decode.
package rrag_pkg;

  localparam int unsigned STRIDE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_ZF = 2'd2,
    ST_FIN     = 2'd3
  } rrag_state_e;

  typedef enum logic [1:0] {
    COND_REP   = 2'd0,
    COND_REPE  = 2'd1,
    COND_REPNE = 2'd2,
    COND_RSVD  = 2'd3
  } rrag_cond_e;

  // Element size exponent to byte stride (1/2/4/8).
  function automatic logic [STRIDE_W-1:0] stride_of(input logic [1:0] opsize);
    logic [STRIDE_W-1:0] s;
    case (opsize)
      2'd0:    s = 4'd1;
      2'd1:    s = 4'd2;
      2'd2:    s = 4'd4;
      default: s = 4'd8;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rrag_rep_addr_step.sv
// Combinational +/- stride step for one string pointer; in 16b addressing
// only bits [15:0] wrap and the upper bits are held.
module rrag_rep_addr_step
  import rrag_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        opsize,
  input  logic              df,
  input  logic              addrmode,
  output logic [ADDR_W-1:0] next_c
);

  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] sum;

  always_comb begin
    stride = ADDR_W'(stride_of(opsize));
    sum    = df ? (addr - stride) : (addr + stride);
    if (addrmode) next_c = sum;
    else          next_c = {addr[ADDR_W-1:16], sum[15:0]};
  end

endmodule

// File: rtl/rrag_rep_seq.sv
// REP-prefixed string instruction sequencer for the RR/AG stage.
// Define RRAG_REP_COND_EN to honour REPE/REPNE termination on ZF.
module rrag_rep_seq
  import rrag_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned MAX_SIZE_LOG2 = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] rep_count,
  input  logic [ADDR_W-1:0] src_offs,
  input  logic [ADDR_W-1:0] dst_offs,
  input  logic [1:0]        opsize,
  input  logic              df,
  input  logic              addrmode,
  input  logic [1:0]        cond,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              zf_valid,
  input  logic              zf,
  output logic              busy,
  output logic              iter_valid,
  output logic [ADDR_W-1:0] iter_src,
  output logic [ADDR_W-1:0] iter_dst,
  output logic [ADDR_W-1:0] iter_cnt,
  output logic              iter_last,
  output logic              done
);

  rrag_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [1:0]        size_q, size_d;
  logic              df_q, df_d;
  logic              amode_q, amode_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] src_step_c, dst_step_c;
  logic [ADDR_W-1:0] eff_cnt_c;
  logic [1:0]        size_cap_c;

`ifdef RRAG_REP_COND_EN
  rrag_cond_e cond_q, cond_d;
  logic       zf_cond_c;
  logic       zf_stop_c;
`else
  logic       unused_ok;
  assign unused_ok = &{1'b0, cond, zf_valid, zf};
`endif

  rrag_rep_addr_step #(.ADDR_W(ADDR_W)) u_src_step (
    .addr(src_q), .opsize(size_q), .df(df_q), .addrmode(amode_q), .next_c(src_step_c)
  );

  rrag_rep_addr_step #(.ADDR_W(ADDR_W)) u_dst_step (
    .addr(dst_q), .opsize(size_q), .df(df_q), .addrmode(amode_q), .next_c(dst_step_c)
  );

  // 16b addressing uses only CX; oversized opsize is clamped to the supported max.
  always_comb begin
    eff_cnt_c  = addrmode ? rep_count : {{(ADDR_W-16){1'b0}}, rep_count[15:0]};
    size_cap_c = ((MAX_SIZE_LOG2 < 3) && (opsize > 2'(MAX_SIZE_LOG2))) ? 2'(MAX_SIZE_LOG2)
                                                                      : opsize;
  end

`ifdef RRAG_REP_COND_EN
  always_comb begin
    zf_cond_c = (cond_q == COND_REPE) || (cond_q == COND_REPNE);
    zf_stop_c = ((cond_q == COND_REPE) && !zf) || ((cond_q == COND_REPNE) && zf) ||
                (cnt_q == '0);
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    dst_d      = dst_q;
    iter_cnt_d = iter_cnt_q;
    size_d     = size_q;
    df_d       = df_q;
    amode_d    = amode_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    last_d     = last_q;
    done_d     = 1'b0;
`ifdef RRAG_REP_COND_EN
    cond_d     = cond_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          cnt_d   = eff_cnt_c;
          src_d   = src_offs;
          dst_d   = dst_offs;
          size_d  = size_cap_c;
          df_d    = df;
          amode_d = addrmode;
`ifdef RRAG_REP_COND_EN
          cond_d  = rrag_cond_e'(cond);
`endif
          busy_d  = 1'b1;
          last_d  = (eff_cnt_c == ADDR_W'(1));
          if (eff_cnt_c == '0) begin
            iter_cnt_d = '0;
            state_d    = ST_FIN;
            done_d     = 1'b1;
          end else begin
            iter_cnt_d = eff_cnt_c - ADDR_W'(1);
            state_d    = ST_ISSUE;
            valid_d    = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (out_ready) begin
          cnt_d      = cnt_q - ADDR_W'(1);
          src_d      = src_step_c;
          dst_d      = dst_step_c;
          iter_cnt_d = cnt_q - ADDR_W'(2);
          last_d     = (cnt_q == ADDR_W'(2));
`ifdef RRAG_REP_COND_EN
          if (zf_cond_c) begin
            state_d = ST_WAIT_ZF;
            valid_d = 1'b0;
          end else
`endif
          if (last_q) begin
            state_d = ST_FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

`ifdef RRAG_REP_COND_EN
      ST_WAIT_ZF: begin
        if (zf_valid) begin
          if (zf_stop_c) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            valid_d = 1'b1;
          end
        end
      end
`endif

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    // Flush wins over start and transfer.
    if (flush) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      iter_cnt_q <= '0;
      size_q     <= '0;
      df_q       <= 1'b0;
      amode_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RRAG_REP_COND_EN
      cond_q     <= COND_REP;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      iter_cnt_q <= iter_cnt_d;
      size_q     <= size_d;
      df_q       <= df_d;
      amode_q    <= amode_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
`ifdef RRAG_REP_COND_EN
      cond_q     <= cond_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign iter_valid = valid_q;
  assign iter_src   = src_q;
  assign iter_dst   = dst_q;
  assign iter_cnt   = iter_cnt_q;
  assign iter_last  = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rrag_rep_seq.sv
// Directed self-checking bench for rrag_rep_seq.
module tb_rrag_rep_seq;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              clr;
  logic              start;
  logic [ADDR_W-1:0] rep_count;
  logic [ADDR_W-1:0] src_offs;
  logic [ADDR_W-1:0] dst_offs;
  logic [1:0]        opsize;
  logic              df;
  logic              addrmode;
  logic [1:0]        cond;
  logic              out_ready;
  logic              flush;
  logic              zf_valid;
  logic              zf;
  logic              busy;
  logic              iter_valid;
  logic [ADDR_W-1:0] iter_src;
  logic [ADDR_W-1:0] iter_dst;
  logic [ADDR_W-1:0] iter_cnt;
  logic              iter_last;
  logic              done;

  int n_checks;
  int n_fail;

  rrag_rep_seq #(.ADDR_W(ADDR_W), .MAX_SIZE_LOG2(3)) dut (
    .clk(clk), .clr(clr), .start(start), .rep_count(rep_count),
    .src_offs(src_offs), .dst_offs(dst_offs), .opsize(opsize), .df(df),
    .addrmode(addrmode), .cond(cond), .out_ready(out_ready), .flush(flush),
    .zf_valid(zf_valid), .zf(zf), .busy(busy), .iter_valid(iter_valid),
    .iter_src(iter_src), .iter_dst(iter_dst), .iter_cnt(iter_cnt),
    .iter_last(iter_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] cnt, input logic [31:0] s, input logic [31:0] d,
                        input logic [1:0] sz, input logic dir, input logic am,
                        input logic [1:0] cc);
    rep_count = cnt; src_offs = s; dst_offs = d;
    opsize = sz; df = dir; addrmode = am; cond = cc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    clr = 1'b0; start = 1'b0; rep_count = '0; src_offs = '0; dst_offs = '0;
    opsize = '0; df = 1'b0; addrmode = 1'b1; cond = 2'b00; out_ready = 1'b1;
    flush = 1'b0; zf_valid = 1'b0; zf = 1'b0;

    #3;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(iter_valid), 32'd0);
    check("rst_outs",  iter_src | iter_dst | iter_cnt, 32'd0);
    check("rst_flags", 32'({iter_last, done}), 32'd0);
    step();
    clr = 1'b1;
    step();

    // forward 32b run, stride 4
    launch(32'd3, 32'h1000, 32'h2000, 2'd2, 1'b0, 1'b1, 2'b00);
    check("fw_c1_valid", 32'(iter_valid), 32'd1);
    check("fw_c1_busy",  32'(busy), 32'd1);
    check("fw_c1_src",   iter_src, 32'h1000);
    check("fw_c1_dst",   iter_dst, 32'h2000);
    check("fw_c1_cnt",   iter_cnt, 32'd2);
    check("fw_c1_last",  32'(iter_last), 32'd0);
    step();
    check("fw_c2_src", iter_src, 32'h1004);
    check("fw_c2_dst", iter_dst, 32'h2004);
    check("fw_c2_cnt", iter_cnt, 32'd1);
    step();
    check("fw_c3_src",  iter_src, 32'h1008);
    check("fw_c3_dst",  iter_dst, 32'h2008);
    check("fw_c3_last", 32'(iter_last), 32'd1);
    check("fw_c3_cnt",  iter_cnt, 32'd0);
    step();
    check("fw_c4_done",  32'(done), 32'd1);
    check("fw_c4_busy",  32'(busy), 32'd1);
    check("fw_c4_valid", 32'(iter_valid), 32'd0);
    step();
    check("fw_c5_busy", 32'(busy), 32'd0);
    check("fw_c5_done", 32'(done), 32'd0);

    // backward 16b run, stride 2, low half wraps
    launch(32'd2, 32'hABCD0001, 32'h00000010, 2'd1, 1'b1, 1'b0, 2'b00);
    check("bw_c1_src", iter_src, 32'hABCD0001);
    check("bw_c1_dst", iter_dst, 32'h00000010);
    step();
    check("bw_c2_src",  iter_src, 32'hABCDFFFF);
    check("bw_c2_dst",  iter_dst, 32'h0000000E);
    check("bw_c2_last", 32'(iter_last), 32'd1);
    step();
    check("bw_c3_done", 32'(done), 32'd1);
    step();
    check("bw_c4_busy", 32'(busy), 32'd0);

    // zero counts: 32b zero, and 16b with only upper bits set
    for (int k = 0; k < 2; k++) begin
      if (k == 0) launch(32'h00000000, 32'h10, 32'h20, 2'd0, 1'b0, 1'b1, 2'b00);
      else        launch(32'h12340000, 32'h10, 32'h20, 2'd0, 1'b0, 1'b0, 2'b00);
      check($sformatf("zc%0d_c1_valid", k), 32'(iter_valid), 32'd0);
      check($sformatf("zc%0d_c1_done", k),  32'(done), 32'd1);
      check($sformatf("zc%0d_c1_busy", k),  32'(busy), 32'd1);
      step();
      check($sformatf("zc%0d_c2_busy", k),  32'(busy), 32'd0);
      check($sformatf("zc%0d_c2_valid", k), 32'(iter_valid), 32'd0);
    end

    // backpressure: three stalled cycles in ISSUE
    out_ready = 1'b0;
    launch(32'd2, 32'h100, 32'h200, 2'd0, 1'b0, 1'b1, 2'b00);
    check("bp_c1_src", iter_src, 32'h100);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold%0d_valid", k), 32'(iter_valid), 32'd1);
      check($sformatf("bp_hold%0d_src", k),   iter_src, 32'h100);
      check($sformatf("bp_hold%0d_cnt", k),   iter_cnt, 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_i2_src",  iter_src, 32'h101);
    check("bp_i2_dst",  iter_dst, 32'h201);
    check("bp_i2_last", 32'(iter_last), 32'd1);
    step();
    check("bp_done", 32'(done), 32'd1);
    step();
    check("bp_idle", 32'(busy), 32'd0);

    // flush after two transfers; a start in the flush cycle is ignored
    launch(32'd5, 32'h3000, 32'h4000, 2'd3, 1'b0, 1'b1, 2'b00);
    step();
    step();
    check("fl_c3_src", iter_src, 32'h3010);
    flush = 1'b1;
    start = 1'b1;
    rep_count = 32'd7;
    step();
    flush = 1'b0;
    start = 1'b0;
    check("fl_valid", 32'(iter_valid), 32'd0);
    check("fl_busy",  32'(busy), 32'd0);
    check("fl_done",  32'(done), 32'd0);
    launch(32'd1, 32'h50, 32'h60, 2'd0, 1'b0, 1'b1, 2'b00);
    check("fl_new_valid", 32'(iter_valid), 32'd1);
    check("fl_new_src",   iter_src, 32'h50);
    check("fl_new_last",  32'(iter_last), 32'd1);
    step();
    check("fl_new_done", 32'(done), 32'd1);
    step();

    // asynchronous reset in the middle of ISSUE
    launch(32'd3, 32'h700, 32'h800, 2'd0, 1'b0, 1'b1, 2'b00);
    check("ar_pre_valid", 32'(iter_valid), 32'd1);
    #2;
    clr = 1'b0;
    #1;
    check("ar_valid", 32'(iter_valid), 32'd0);
    check("ar_busy",  32'(busy), 32'd0);
    check("ar_outs",  iter_src | iter_dst | iter_cnt, 32'd0);
    #1;
    clr = 1'b1;
    step();
    check("ar_post_busy", 32'(busy), 32'd0);

`ifdef RRAG_REP_COND_EN
    // REPE: ZF=1 after iterations 1-2, ZF=0 after iteration 3
    begin
      int n_iter;
      int seen_done;
      n_iter = 0; seen_done = 0;
      zf_valid = 1'b1;
      zf = 1'b1;
      launch(32'd4, 32'h10, 32'h90, 2'd0, 1'b0, 1'b1, 2'b01);
      for (int k = 0; k < 30 && seen_done == 0; k++) begin
        if (iter_valid) begin
          n_iter++;
          if (n_iter == 3) check("cz_i3_src", iter_src, 32'h12);
        end
        if (done) seen_done = 1;
        zf = (n_iter <= 2);
        if (seen_done == 0) step();
      end
      zf_valid = 1'b0;
      check("cz_iters", 32'(n_iter), 32'd3);
      check("cz_done",  32'(seen_done), 32'd1);
      step();
      check("cz_idle", 32'(busy), 32'd0);
    end
`else
    // without the feature REPE runs back to back as plain REP
    launch(32'd2, 32'h10, 32'h90, 2'd0, 1'b0, 1'b1, 2'b01);
    check("nc_c1_src", iter_src, 32'h10);
    step();
    check("nc_c2_valid", 32'(iter_valid), 32'd1);
    check("nc_c2_src",   iter_src, 32'h11);
    step();
    check("nc_done", 32'(done), 32'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
